// File: rtl/ddc_multi_config_ctl.sv
// Multi-channel DDC configuration controller.
// Routes one valid-qualified config word stream to the mixer and filter
// chain of one selected DDC channel (or all channels in broadcast), counts
// segment lengths, gathers per-channel done flags and reports completion,
// bad-select or timeout to the register side.
//
// Stream handshake: Data_Config_Valid qualifies Data_Config_In for exactly
// one cycle; there is no ready, so every valid word seen in MIXER or DDCF is
// consumed immediately, and valid words seen in IDLE or WAIT_DONE are dropped.
module ddc_multi_config_ctl #(
    parameter int CONFIG_WIDTH = 32,
    parameter int NUM_CH       = 4,
    parameter int CH_SEL_W     = 2,
    parameter int MIXER_WORDS  = 2,
    parameter int FILTER_WORDS = 1216,
    parameter int CNT_W        = 12,
    parameter int TIMEOUT_CYC  = 4096
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    isConfig,
    input  logic [CH_SEL_W-1:0]     Config_Ch_Sel,
    input  logic                    Config_Broadcast,
    input  logic                    Data_Config_Valid,
    input  logic [CONFIG_WIDTH-1:0] Data_Config_In,
    output logic                    isConfigACK,
    output logic                    isConfigDone,
    output logic                    isConfigErr,
    output logic [CNT_W-1:0]        Word_Cnt,
    output logic [NUM_CH-1:0]       isConfig_MIXER,
    output logic [CONFIG_WIDTH-1:0] Data_Config_Out_MIXER,
    input  logic [NUM_CH-1:0]       isConfigDone_MIXER,
    output logic [NUM_CH-1:0]       isConfig_DDCF,
    output logic [CONFIG_WIDTH-1:0] Data_Config_Out_DDCF,
    input  logic [NUM_CH-1:0]       isConfigDone_DDCF,
    output logic [1:0]              dbgState
);

    localparam int TMR_W = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MIXER     = 2'd1,
        DDCF      = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t            state;
    logic [NUM_CH-1:0] targetMask;
    logic [NUM_CH-1:0] doneSticky;
    logic [TMR_W-1:0]  waitTimer;

    logic [NUM_CH-1:0] bothDone;
    logic [NUM_CH-1:0] stickyNext;
    logic [NUM_CH-1:0] startMask;
    logic [31:0]       selWide;
    logic              selBad;

    // Start-request decode and running done collection.
    always_comb begin
        bothDone   = isConfigDone_MIXER & isConfigDone_DDCF;
        stickyNext = doneSticky | bothDone;
        selWide    = {{(32-CH_SEL_W){1'b0}}, Config_Ch_Sel};
        selBad     = !Config_Broadcast && (selWide >= NUM_CH);
        startMask  = Config_Broadcast ? {NUM_CH{1'b1}}
                                      : (NUM_CH'(1) << Config_Ch_Sel);
    end

    // Configuration sequencer: start, word routing, done/timeout wait.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state                 <= IDLE;
            targetMask            <= '0;
            doneSticky            <= '0;
            waitTimer             <= '0;
            Word_Cnt              <= '0;
            isConfigACK           <= 1'b0;
            isConfigDone          <= 1'b0;
            isConfigErr           <= 1'b0;
            isConfig_MIXER        <= '0;
            Data_Config_Out_MIXER <= '0;
            isConfig_DDCF         <= '0;
            Data_Config_Out_DDCF  <= '0;
        end else begin
            // Pulses and strobes are single-cycle unless re-asserted below.
            isConfigDone   <= 1'b0;
            isConfigErr    <= 1'b0;
            isConfig_MIXER <= '0;
            isConfig_DDCF  <= '0;
            case (state)
                IDLE: begin
                    if (isConfig) begin
                        if (selBad) begin
                            isConfigErr <= 1'b1;
                        end else begin
                            targetMask  <= startMask;
                            doneSticky  <= '0;
                            Word_Cnt    <= '0;
                            waitTimer   <= '0;
                            isConfigACK <= 1'b1;
                            state       <= MIXER;
                        end
                    end
                end
                MIXER: begin
                    doneSticky <= stickyNext;
                    if (Data_Config_Valid) begin
                        Data_Config_Out_MIXER <= Data_Config_In;
                        isConfig_MIXER        <= targetMask;
                        if (Word_Cnt == CNT_W'(MIXER_WORDS - 1)) begin
                            Word_Cnt <= '0;
                            state    <= DDCF;
                        end else begin
                            Word_Cnt <= Word_Cnt + CNT_W'(1);
                        end
                    end
                end
                DDCF: begin
                    doneSticky <= stickyNext;
                    if (Data_Config_Valid) begin
                        Data_Config_Out_DDCF <= Data_Config_In;
                        isConfig_DDCF        <= targetMask;
                        if (Word_Cnt == CNT_W'(FILTER_WORDS - 1)) begin
                            Word_Cnt  <= '0;
                            waitTimer <= '0;
                            state     <= WAIT_DONE;
                        end else begin
                            Word_Cnt <= Word_Cnt + CNT_W'(1);
                        end
                    end
                end
                WAIT_DONE: begin
                    doneSticky <= stickyNext;
                    // Completion is checked before the timer so a tie reports Done.
                    if ((stickyNext & targetMask) == targetMask) begin
                        isConfigDone <= 1'b1;
                        isConfigACK  <= 1'b0;
                        state        <= IDLE;
                    end else if (waitTimer == TMR_W'(TIMEOUT_CYC - 1)) begin
                        isConfigErr <= 1'b1;
                        isConfigACK <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        waitTimer <= waitTimer + TMR_W'(1);
                    end
                end
                default: begin
                    isConfigACK <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign dbgState = state;

endmodule

// File: tb/tb_ddc_multi_config_ctl.sv
// Self-checking bench for ddc_multi_config_ctl (4-channel instance with short
// segments and timeout, plus a 3-channel instance for bad-select handling).
module tb_ddc_multi_config_ctl;

    localparam int CW    = 32;
    localparam int NCH   = 4;
    localparam int MW    = 2;
    localparam int FW    = 5;
    localparam int TO    = 16;
    localparam int TOTAL = MW + FW;

    // ---------------- clock / reset ----------------
    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // ---------------- stimulus / observed signals ----------------
    logic           isConfig  = 1'b0;
    logic           isConfig3 = 1'b0;
    logic [1:0]     chSel     = '0;
    logic           bcast     = 1'b0;
    logic           valid     = 1'b0;
    logic [CW-1:0]  dataIn    = '0;
    logic [NCH-1:0] doneM     = '0;
    logic [NCH-1:0] doneD     = '0;
    logic [2:0]     doneM3    = '0;
    logic [2:0]     doneD3    = '0;

    logic           ack, done, err;
    logic [11:0]    wordCnt;
    logic [NCH-1:0] strM, strD;
    logic [CW-1:0]  dataM, dataD;
    logic [1:0]     dbg;

    logic           ack3, done3, err3;
    logic [11:0]    wordCnt3;
    logic [2:0]     strM3, strD3;
    logic [CW-1:0]  dataM3, dataD3;
    logic [1:0]     dbg3;

    ddc_multi_config_ctl #(
        .CONFIG_WIDTH(CW), .NUM_CH(NCH), .CH_SEL_W(2), .MIXER_WORDS(MW),
        .FILTER_WORDS(FW), .CNT_W(12), .TIMEOUT_CYC(TO)
    ) dut (
        .CLK(CLK), .nRST(nRST), .isConfig(isConfig), .Config_Ch_Sel(chSel),
        .Config_Broadcast(bcast), .Data_Config_Valid(valid), .Data_Config_In(dataIn),
        .isConfigACK(ack), .isConfigDone(done), .isConfigErr(err), .Word_Cnt(wordCnt),
        .isConfig_MIXER(strM), .Data_Config_Out_MIXER(dataM), .isConfigDone_MIXER(doneM),
        .isConfig_DDCF(strD), .Data_Config_Out_DDCF(dataD), .isConfigDone_DDCF(doneD),
        .dbgState(dbg)
    );

    ddc_multi_config_ctl #(
        .CONFIG_WIDTH(CW), .NUM_CH(3), .CH_SEL_W(2), .MIXER_WORDS(MW),
        .FILTER_WORDS(FW), .CNT_W(12), .TIMEOUT_CYC(TO)
    ) dut3 (
        .CLK(CLK), .nRST(nRST), .isConfig(isConfig3), .Config_Ch_Sel(chSel),
        .Config_Broadcast(bcast), .Data_Config_Valid(valid), .Data_Config_In(dataIn),
        .isConfigACK(ack3), .isConfigDone(done3), .isConfigErr(err3), .Word_Cnt(wordCnt3),
        .isConfig_MIXER(strM3), .Data_Config_Out_MIXER(dataM3), .isConfigDone_MIXER(doneM3),
        .isConfig_DDCF(strD3), .Data_Config_Out_DDCF(dataD3), .isConfigDone_DDCF(doneD3),
        .dbgState(dbg3)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;

    logic [CW-1:0]  expMixQ[$];
    logic [CW-1:0]  expDdcfQ[$];
    logic [NCH-1:0] expMask;
    int             doneCycQ[$];
    int             errCycQ[$];
    int             ackRise, ackFall, ackRiseCnt;
    int             mixSeen, ddcfSeen;
    // Done pulse offsets (cycles after the start cycle) per channel; 0 = never.
    int             mixOff[NCH];
    int             ddcfOff[NCH];

    // Reference model: cycle on which the Done/Err pulse is visible, given the
    // start cycle s and the cycle l that carried the last word.
    function automatic int model_end(input int s, input int l, input logic [NCH-1:0] m,
                                     output logic wantDone);
        int d;
        d = l + 1;
        wantDone = 1'b1;
        for (int ch = 0; ch < NCH; ch++) begin
            if (m[ch]) begin
                if (mixOff[ch] > 0 && mixOff[ch] == ddcfOff[ch]) begin
                    if (s + mixOff[ch] > d) d = s + mixOff[ch];
                end else begin
                    wantDone = 1'b0;
                end
            end
        end
        if (wantDone && d <= l + TO) return d + 1;
        wantDone = 1'b0;
        return l + 1 + TO;
    endfunction

    // ---------------- driver + scoreboard ----------------
    // Runs one configuration: start pulse, TOTAL words with random gaps,
    // done pulses per mixOff/ddcfOff, optional ignored restart, optional abort
    // by reset after abortAfter words. Strobes are checked against the
    // expected queues each cycle; the outcome is checked at the end.
    task automatic drive_config(input logic [1:0] sel, input logic bc, input int gapPct,
                                input logic [CW-1:0] base, input int restartAt,
                                input int abortAfter, output int s, output int l);
        int sent, accd, c, maxOff, expCnt, e;
        logic [CW-1:0] exp;
        logic prevAck, wantDone;
        sent = 0; accd = 0; l = -1; maxOff = 0; prevAck = 1'b0;
        for (int ch = 0; ch < NCH; ch++) begin
            if (mixOff[ch] > maxOff) maxOff = mixOff[ch];
            if (ddcfOff[ch] > maxOff) maxOff = ddcfOff[ch];
        end
        expMask = bc ? {NCH{1'b1}} : (NCH'(1) << sel);
        expMixQ.delete(); expDdcfQ.delete(); doneCycQ.delete(); errCycQ.delete();
        ackRise = -1; ackFall = -1; ackRiseCnt = 0; mixSeen = 0; ddcfSeen = 0;

        @(posedge CLK); #1;
        s = cyc; c = s;
        isConfig = 1'b1; chSel = sel; bcast = bc; valid = 1'b0;
        while (1) begin
            @(negedge CLK);
            if (strM !== '0) begin
                mixSeen++;
                checks++;
                if (expMixQ.size() == 0) begin
                    errors++;
                    $display("FAIL mixer_strobe_extra: got mask %b data %h, expected no strobe", strM, dataM);
                end else begin
                    exp = expMixQ.pop_front();
                    if (dataM !== exp || strM !== expMask) begin
                        errors++;
                        $display("FAIL mixer_word: got mask %b data %h, expected mask %b data %h", strM, dataM, expMask, exp);
                    end
                end
            end
            if (strD !== '0) begin
                ddcfSeen++;
                checks++;
                if (expDdcfQ.size() == 0) begin
                    errors++;
                    $display("FAIL ddcf_strobe_extra: got mask %b data %h, expected no strobe", strD, dataD);
                end else begin
                    exp = expDdcfQ.pop_front();
                    if (dataD !== exp || strD !== expMask) begin
                        errors++;
                        $display("FAIL ddcf_word: got mask %b data %h, expected mask %b data %h", strD, dataD, expMask, exp);
                    end
                end
            end
            expCnt = (accd < MW) ? accd : ((accd < TOTAL) ? accd - MW : 0);
            checks++;
            if (wordCnt !== 12'(expCnt)) begin
                errors++;
                $display("FAIL word_cnt: cycle %0d got %0d expected %0d", c - s, wordCnt, expCnt);
            end
            if (done === 1'b1) doneCycQ.push_back(c);
            if (err === 1'b1) errCycQ.push_back(c);
            if (ack === 1'b1 && !prevAck) begin ackRise = c; ackRiseCnt++; end
            if (ack !== 1'b1 && prevAck) ackFall = c;
            prevAck = (ack === 1'b1);

            if (sent == TOTAL && c >= l + TO + 2 && c >= s + maxOff + 2) break;
            if (c > s + 2000) begin
                checks++; errors++;
                $display("FAIL run_budget: words sent %0d of %0d", sent, TOTAL);
                break;
            end

            @(posedge CLK); #1;
            c = cyc;
            accd = sent;
            if (abortAfter > 0 && sent == abortAfter) begin
                valid = 1'b0; doneM = '0; doneD = '0; isConfig = 1'b0;
                nRST = 1'b0;
                #1;
                return;
            end
            isConfig = (restartAt > 0 && c == s + restartAt);
            bcast    = (restartAt > 0 && c == s + restartAt);
            for (int ch = 0; ch < NCH; ch++) begin
                doneM[ch] = (mixOff[ch] > 0 && c == s + mixOff[ch]);
                doneD[ch] = (ddcfOff[ch] > 0 && c == s + ddcfOff[ch]);
            end
            if (sent < TOTAL && $urandom_range(99) >= gapPct) begin
                valid  = 1'b1;
                dataIn = base + CW'(sent);
                if (sent < MW) expMixQ.push_back(dataIn);
                else expDdcfQ.push_back(dataIn);
                sent++;
                if (sent == TOTAL) l = c;
            end else begin
                valid  = 1'b0;
                dataIn = $urandom;
            end
        end
        valid = 1'b0; doneM = '0; doneD = '0; isConfig = 1'b0; bcast = 1'b0;

        e = model_end(s, l, expMask, wantDone);
        checks++;
        if (ackRiseCnt != 1 || ackRise != s + 1) begin
            errors++;
            $display("FAIL ack_rise: got %0d rises, first at +%0d, expected 1 at +1", ackRiseCnt, ackRise - s);
        end
        checks++;
        if (ackFall != e) begin
            errors++;
            $display("FAIL ack_fall: got +%0d expected +%0d", ackFall - s, e - s);
        end
        checks++;
        if (doneCycQ.size() != (wantDone ? 1 : 0) || (wantDone && doneCycQ[0] != e)) begin
            errors++;
            $display("FAIL done_pulse: got %0d pulses, expected %0d at +%0d", doneCycQ.size(), wantDone, e - s);
        end
        checks++;
        if (errCycQ.size() != (wantDone ? 0 : 1) || (!wantDone && errCycQ[0] != e)) begin
            errors++;
            $display("FAIL err_pulse: got %0d pulses, expected %0d at +%0d", errCycQ.size(), !wantDone, e - s);
        end
        checks++;
        if (mixSeen != MW || ddcfSeen != FW) begin
            errors++;
            $display("FAIL word_totals: got mixer %0d ddcf %0d, expected %0d and %0d", mixSeen, ddcfSeen, MW, FW);
        end
    endtask

    task automatic clear_offsets();
        for (int ch = 0; ch < NCH; ch++) begin
            mixOff[ch] = 0;
            ddcfOff[ch] = 0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if ({ack, done, err, wordCnt, strM, strD, dataM, dataD} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ack %b done %b err %b cnt %0d strM %b strD %b", ack, done, err, wordCnt, strM, strD);
        end
        checks++;
        if ({ack3, done3, err3, wordCnt3, strM3, strD3, dataM3, dataD3} !== '0) begin
            errors++;
            $display("FAIL reset_outputs3: got ack %b done %b err %b", ack3, done3, err3);
        end
        nRST = 1'b1;
        // Valid words while idle must be ignored.
        repeat (3) begin
            @(posedge CLK); #1;
            valid = 1'b1; dataIn = $urandom;
        end
        @(posedge CLK); #1;
        valid = 1'b0;
        @(posedge CLK); #1;
        checks++;
        if ({ack, done, err, wordCnt, strM, strD} !== '0) begin
            errors++;
            $display("FAIL idle_ignores_words: got ack %b strM %b strD %b cnt %0d, expected all 0", ack, strM, strD, wordCnt);
        end
    endtask

    task automatic test_single();
        int s, l;
        clear_offsets();
        mixOff[2] = 10; ddcfOff[2] = 10;
        drive_config(2'd2, 1'b0, 0, 32'h10, 0, 0, s, l);
        checks++;
        if (l != s + 7) begin
            errors++;
            $display("FAIL single_last_word: got +%0d expected +7", l - s);
        end
        checks++;
        if (doneCycQ.size() != 1 || doneCycQ[0] != s + 11 || ackFall != s + 11) begin
            errors++;
            $display("FAIL single_done: got %0d pulses ack fall +%0d, expected done and ack fall at +11", doneCycQ.size(), ackFall - s);
        end
    endtask

    task automatic test_broadcast_gaps();
        int s, l, last;
        clear_offsets();
        last = 0;
        for (int ch = 0; ch < NCH; ch++) begin
            mixOff[ch]  = 3 + 4 * ch + int'($urandom_range(1));
            ddcfOff[ch] = mixOff[ch];
            if (mixOff[ch] > last) last = mixOff[ch];
        end
        drive_config(2'd0, 1'b1, 50, $urandom, 0, 0, s, l);
        checks++;
        if (doneCycQ.size() != 1 || doneCycQ[0] <= s + last || doneCycQ[0] <= l + 1) begin
            errors++;
            $display("FAIL broadcast_done_order: got %0d pulses, last channel done at +%0d", doneCycQ.size(), last);
        end
    endtask

    task automatic test_timeout();
        int s, l;
        clear_offsets();
        mixOff[1] = 3;
        drive_config(2'd1, 1'b0, 0, $urandom, 0, 0, s, l);
        checks++;
        if (errCycQ.size() != 1 || errCycQ[0] != s + 24 || doneCycQ.size() != 0) begin
            errors++;
            $display("FAIL timeout_err: got %0d err pulses %0d done pulses, expected one err at +24", errCycQ.size(), doneCycQ.size());
        end
    endtask

    task automatic test_bad_select();
        @(posedge CLK); #1;
        isConfig3 = 1'b1; chSel = 2'd3; bcast = 1'b0;
        @(posedge CLK); #1;
        isConfig3 = 1'b0;
        checks++;
        if (err3 !== 1'b1 || ack3 !== 1'b0) begin
            errors++;
            $display("FAIL bad_select_err: got err %b ack %b, expected err 1 ack 0", err3, ack3);
        end
        for (int i = 0; i < 6; i++) begin
            valid = 1'b1; dataIn = $urandom;
            @(posedge CLK); #1;
            checks++;
            if ({err3, ack3, strM3, strD3, wordCnt3} !== '0 || {strM, strD} !== '0) begin
                errors++;
                $display("FAIL bad_select_quiet: cycle %0d got err %b ack %b strM %b strD %b, expected all 0", i, err3, ack3, strM3, strD3);
            end
        end
        valid = 1'b0;
    endtask

    task automatic test_restart_and_reset();
        int s, l;
        clear_offsets();
        mixOff[0] = 9; ddcfOff[0] = 9;
        drive_config(2'd0, 1'b0, 0, $urandom, 5, 0, s, l);

        clear_offsets();
        drive_config(2'd2, 1'b0, 0, $urandom, 0, 4, s, l);
        checks++;
        if ({ack, done, err, wordCnt, strM, strD, dataM, dataD} !== '0) begin
            errors++;
            $display("FAIL reset_abort: got ack %b cnt %0d strM %b strD %b dataM %h, expected all 0", ack, wordCnt, strM, strD, dataM);
        end
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
        for (int i = 0; i < TO + 4; i++) begin
            @(posedge CLK); #1;
            checks++;
            if ({done, err, ack} !== 3'b000) begin
                errors++;
                $display("FAIL abort_no_pulse: cycle %0d got done %b err %b ack %b, expected 0", i, done, err, ack);
            end
        end
        clear_offsets();
        mixOff[3] = 12; ddcfOff[3] = 12;
        drive_config(2'd3, 1'b0, 30, $urandom, 0, 0, s, l);
    endtask

    task automatic test_done_timeout_tie();
        int s, l;
        clear_offsets();
        mixOff[3] = 7 + TO; ddcfOff[3] = 7 + TO;
        drive_config(2'd3, 1'b0, 0, $urandom, 0, 0, s, l);
        checks++;
        if (doneCycQ.size() != 1 || doneCycQ[0] != s + 24 || errCycQ.size() != 0) begin
            errors++;
            $display("FAIL tie_done_wins: got %0d done %0d err pulses, expected one done at +24", doneCycQ.size(), errCycQ.size());
        end
    endtask

    task automatic test_random();
        int s, l;
        for (int it = 0; it < 6; it++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                mixOff[ch]  = $urandom_range(30);
                ddcfOff[ch] = ($urandom_range(3) == 0) ? int'($urandom_range(30)) : mixOff[ch];
            end
            drive_config(2'($urandom_range(3)), 1'($urandom_range(1)), $urandom_range(60),
                         $urandom, 0, 0, s, l);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single();
        test_broadcast_gaps();
        test_timeout();
        test_bad_select();
        test_restart_and_reset();
        test_done_timeout_tie();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
